// File: rtl/cmd_frame_rcv.sv
// Framed command receiver: takes UART bytes SYNC, CMD_HI, CMD_LO, CHK and hands each
// checksum-verified 16-bit command to the dispatcher. Bad or stalled frames are counted.
module cmd_frame_rcv #(
  parameter logic [7:0] SYNC     = 8'hA5,
  parameter int         LOCK_CYC = 2604,
  parameter int         TO_CYC   = 104160
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rx_rdy,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  output logic        frame_err,
  output logic [7:0]  err_cnt
);

  typedef enum logic [1:0] {SYNC_WAIT, GET_HI, GET_LO, GET_CHK} state_t;

  localparam int            LW        = $clog2(LOCK_CYC + 1);
  localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCK_CYC - 1);
  localparam logic [16:0]   TO_LAST   = 17'(TO_CYC - 1);

  state_t        state, state_nxt;
  logic [LW-1:0] lock_cnt;
  logic [16:0]   to_cnt;
  logic [7:0]    hi, lo;
  logic          lock_act, accept, timeout, good, bad;

  function automatic logic [7:0] chk_of(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] s;
    s = a + b;
    return ~s;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign lock_act   = (lock_cnt != '0);
  assign clr_rx_rdy = lock_act;
  assign accept     = rx_rdy && !lock_act;
  assign timeout    = (state != SYNC_WAIT) && !accept && (to_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SYNC_WAIT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    good      = 1'b0;
    bad       = 1'b0;
    if (accept) begin
      case (state)
        SYNC_WAIT: if (rx_data == SYNC) state_nxt = GET_HI;
        GET_HI:    state_nxt = GET_LO;
        GET_LO:    state_nxt = GET_CHK;
        GET_CHK: begin
          state_nxt = SYNC_WAIT;
          if (rx_data == chk_of(hi, lo)) good = 1'b1;
          else                           bad  = 1'b1;
        end
        default:   state_nxt = SYNC_WAIT;
      endcase
    end else if (timeout) begin
      state_nxt = SYNC_WAIT;
      bad       = 1'b1;
    end
  end

  // Payload bytes carry no reset value; they are only consumed after being written.
  always_ff @(posedge clk) begin
    if (accept && state == GET_HI) hi <= rx_data;
    if (accept && state == GET_LO) lo <= rx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_cnt  <= '0;
      to_cnt    <= '0;
      cmd       <= 16'h0000;
      cmd_rdy   <= 1'b0;
      frame_err <= 1'b0;
      err_cnt   <= 8'h00;
    end else begin
      if (accept)        lock_cnt <= LOCK_LOAD;
      else if (lock_act) lock_cnt <= lock_cnt - LW'(1);

      if (accept || timeout || state == SYNC_WAIT) to_cnt <= '0;
      else                                         to_cnt <= to_cnt + 17'd1;

      // Completion outranks a simultaneous acknowledge.
      if (good) begin
        cmd     <= {hi, lo};
        cmd_rdy <= 1'b1;
      end else if (clr_cmd_rdy) begin
        cmd_rdy <= 1'b0;
      end

      frame_err <= bad;
      if (bad) err_cnt <= sat_inc(err_cnt);
    end
  end

endmodule

// File: tb/tb_cmd_frame_rcv.sv
// Bench for cmd_frame_rcv: a cycle-indexed frame model checked against the DUT every
// cycle, plus directed frames with hand-computed expectations.
module tb_cmd_frame_rcv;

  localparam int LOCK = 16;
  localparam int TO   = 300;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_rdy = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        clr_cmd_rdy = 1'b0;
  logic        clr_rx_rdy;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        frame_err;
  logic [7:0]  err_cnt;

  always #5 clk = ~clk;

  cmd_frame_rcv #(.SYNC(8'hA5), .LOCK_CYC(LOCK), .TO_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_rdy(rx_rdy), .rx_data(rx_data),
    .clr_rx_rdy(clr_rx_rdy), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .frame_err(frame_err), .err_cnt(err_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: edges are numbered; a byte is taken if LOCK edges have passed since the last one.
  longint      e;
  longint      acc_e;
  int          nb;
  logic [7:0]  m_hi, m_lo, m_sum;
  logic [15:0] m_cmd;
  logic        m_rdy, m_ferr, m_clr;
  logic [7:0]  m_err;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        e = 0; acc_e = -1000000; nb = 0;
        m_cmd = 16'h0; m_rdy = 1'b0; m_ferr = 1'b0; m_err = 8'h0; m_clr = 1'b0;
      end else begin
        logic good, bad;
        good = 1'b0; bad = 1'b0;
        e++;
        if (rx_rdy && (e - acc_e >= LOCK)) begin
          acc_e = e;
          if (nb == 0) begin
            if (rx_data == 8'hA5) nb = 1;
          end else if (nb == 1) begin
            m_hi = rx_data; nb = 2;
          end else if (nb == 2) begin
            m_lo = rx_data; nb = 3;
          end else begin
            nb = 0;
            m_sum = m_hi + m_lo;
            if (rx_data == ~m_sum) good = 1'b1;
            else                   bad  = 1'b1;
          end
        end else if (nb != 0 && (e - acc_e == TO)) begin
          nb = 0; bad = 1'b1;
        end
        if (good) begin
          m_cmd = {m_hi, m_lo}; m_rdy = 1'b1;
        end else if (clr_cmd_rdy) begin
          m_rdy = 1'b0;
        end
        m_ferr = bad;
        if (bad && m_err != 8'hFF) m_err = m_err + 8'd1;
        m_clr = (e - acc_e) <= LOCK - 2;
      end
    end
  end

  // Per-cycle compare and event monitors.
  int cyc = 0, clr_rises = 0, ferr_pulses = 0, clr_rise_cyc = 0, ferr_cyc = 0;
  logic prev_clr = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n) begin
        chk("cmd", 32'(cmd), 32'(m_cmd));
        chk("cmd_rdy", 32'(cmd_rdy), 32'(m_rdy));
        chk("frame_err", 32'(frame_err), 32'(m_ferr));
        chk("err_cnt", 32'(err_cnt), 32'(m_err));
        chk("clr_rx_rdy", 32'(clr_rx_rdy), 32'(m_clr));
        if (clr_rx_rdy && !prev_clr) begin clr_rises++; clr_rise_cyc = cyc; end
        if (frame_err) begin ferr_pulses++; ferr_cyc = cyc; end
      end
      prev_clr = clr_rx_rdy;
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap, input logic ack);
    rx_data = b; rx_rdy = 1'b1; clr_cmd_rdy = ack;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    repeat (LOCK - 1) @(negedge clk);
    rx_rdy = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic pulse_clr();
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    @(negedge clk);
  endtask

  int r0, f0;
  logic [7:0] t2 [6] = '{8'h00, 8'h7F, 8'hA5, 8'hFF, 8'h01, 8'h00};

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_cmd", 32'(cmd), 32'h0);
    chk("rst_cmd_rdy", 32'(cmd_rdy), 32'h0);
    chk("rst_err_cnt", 32'(err_cnt), 32'h0);
    chk("rst_clr_rx_rdy", 32'(clr_rx_rdy), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Good frame, widely spaced bytes
    r0 = clr_rises; f0 = ferr_pulses;
    send_byte(8'hA5, 9*LOCK, 1'b0);
    send_byte(8'h12, 9*LOCK, 1'b0);
    send_byte(8'h34, 9*LOCK, 1'b0);
    send_byte(8'hB9, 9*LOCK, 1'b0);
    chk("t1_cmd", 32'(cmd), 32'h1234);
    chk("t1_rdy", 32'(cmd_rdy), 32'h1);
    chk("t1_windows", 32'(clr_rises - r0), 32'd4);
    chk("t1_ferr", 32'(ferr_pulses - f0), 32'd0);

    // Junk before SYNC, then a bad checksum
    pulse_clr();
    chk("t2_rdy_cleared", 32'(cmd_rdy), 32'h0);
    f0 = ferr_pulses;
    for (int i = 0; i < 6; i++) send_byte(t2[i], 40, 1'b0);
    chk("t2_ferr", 32'(ferr_pulses - f0), 32'd1);
    chk("t2_err_cnt", 32'(err_cnt), 32'd1);
    chk("t2_rdy", 32'(cmd_rdy), 32'h0);
    chk("t2_cmd", 32'(cmd), 32'h1234);

    // Timeout after A5 AB, then a good frame
    f0 = ferr_pulses;
    send_byte(8'hA5, 0, 1'b0);
    send_byte(8'hAB, 0, 1'b0);
    repeat (TO + 20) @(negedge clk);
    chk("t3_ferr", 32'(ferr_pulses - f0), 32'd1);
    chk("t3_err_cnt", 32'(err_cnt), 32'd2);
    chk("t3_to_delay", 32'(ferr_cyc - clr_rise_cyc), 32'(TO));
    send_byte(8'hA5, 40, 1'b0);
    send_byte(8'h00, 40, 1'b0);
    send_byte(8'h01, 40, 1'b0);
    send_byte(8'hFE, 40, 1'b0);
    chk("t3_cmd", 32'(cmd), 32'h0001);
    chk("t3_rdy", 32'(cmd_rdy), 32'h1);

    // Completion collides with acknowledge
    pulse_clr();
    chk("t4_rdy_pre", 32'(cmd_rdy), 32'h0);
    send_byte(8'hA5, 40, 1'b0);
    send_byte(8'h12, 40, 1'b0);
    send_byte(8'h34, 40, 1'b0);
    send_byte(8'hB9, 40, 1'b1);
    chk("t4_rdy_wins", 32'(cmd_rdy), 32'h1);
    chk("t4_cmd", 32'(cmd), 32'h1234);
    pulse_clr();
    chk("t4_rdy_clr", 32'(cmd_rdy), 32'h0);
    chk("t4_cmd_hold", 32'(cmd), 32'h1234);

    // Saturation, then reset mid-frame
    for (int i = 0; i < 300; i++) begin
      send_byte(8'hA5, 4, 1'b0);
      send_byte(8'h00, 4, 1'b0);
      send_byte(8'h00, 4, 1'b0);
      send_byte(8'h00, 4, 1'b0);
    end
    chk("t5_err_sat", 32'(err_cnt), 32'hFF);
    send_byte(8'hA5, 4, 1'b0);
    send_byte(8'h12, 4, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_cmd", 32'(cmd), 32'h0);
    chk("t5_rst_rdy", 32'(cmd_rdy), 32'h0);
    chk("t5_rst_err", 32'(err_cnt), 32'h0);
    chk("t5_rst_ferr", 32'(frame_err), 32'h0);
    chk("t5_rst_clr", 32'(clr_rx_rdy), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_byte(8'hA5, 4, 1'b0);
    send_byte(8'h12, 4, 1'b0);
    send_byte(8'h34, 4, 1'b0);
    send_byte(8'hB9, 4, 1'b0);
    chk("t5_cmd", 32'(cmd), 32'h1234);
    chk("t5_rdy", 32'(cmd_rdy), 32'h1);
    chk("t5_err", 32'(err_cnt), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
